// File: rtl/data_memory_ws.sv
// Clocked byte-addressable data memory with valid/ready handshake, configurable
// wait states, byte/word access with optional sign extension and fault reporting.
module data_memory_ws #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_CYCLES = 0,
  parameter int INIT_WORDS  = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic              resp_valid,
  output logic [DATA_W-1:0] read_data,
  output logic              fault
);
  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  typedef struct packed {
    logic              wr;
    logic              byte_op;
    logic              sgn;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  req_t        req;
  logic        accept, do_acc, wr_go;
  logic        misaligned, out_range, flt;
  logic [ADDR_W:0]   end_addr;
  logic [DATA_W-1:0] rd_word, load_val;
  logic [7:0]        cell_q [DEPTH_BYTES];

  assign ready  = (state == IDLE);
  assign accept = req_valid && ready;
  assign do_acc = (state == BUSY) && (cnt == 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
      req   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept)
        req <= '{wr: req_write, byte_op: req_byte, sgn: req_signed,
                 addr: address, wdata: write_data};
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (accept) begin
        state_nxt = BUSY;
        cnt_nxt   = 8'(WAIT_CYCLES);
      end
      BUSY: begin
        if (cnt != 8'd0) cnt_nxt = cnt - 8'd1;
        else             state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // End address carries one extra bit so accesses near the top cannot wrap.
  assign end_addr   = {1'b0, req.addr} + (req.byte_op ? (ADDR_W+1)'(1) : (ADDR_W+1)'(BYTES));
  assign misaligned = !req.byte_op && ((req.addr % ADDR_W'(BYTES)) != '0);
  assign out_range  = end_addr > (ADDR_W+1)'(DEPTH_BYTES);
  assign flt        = misaligned || out_range;
  assign wr_go      = do_acc && req.wr && !flt;

  always_comb begin
    rd_word = '0;
    for (int j = 0; j < BYTES; j++)
      if (({1'b0, req.addr} + (ADDR_W+1)'(j)) < (ADDR_W+1)'(DEPTH_BYTES))
        rd_word[8*j +: 8] = cell_q[IDX_W'(req.addr + ADDR_W'(j))];
  end

  assign load_val = req.byte_op ? {{(DATA_W-8){req.sgn & rd_word[7]}}, rd_word[7:0]} : rd_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      fault      <= 1'b0;
      read_data  <= '0;
    end else begin
      resp_valid <= do_acc;
      if (do_acc) begin
        fault     <= flt;
        read_data <= (flt || req.wr) ? '0 : load_val;
      end
    end
  end

  // Each byte cell starts with its slice of the preload image: word k holds k*BYTES.
  for (genvar g = 0; g < DEPTH_BYTES; g++) begin : g_cell
    localparam int K = g / BYTES;
    localparam int J = g % BYTES;
    localparam logic [7:0] INIT = (K < INIT_WORDS && J < 4) ?
                                  8'(((K * BYTES) >> (8 * J)) & 255) : 8'h00;
    logic [ADDR_W:0] off;
    logic [7:0]      wb;
    logic            hit;
    logic [7:0]      q = INIT;

    assign off = (ADDR_W+1)'(g) - {1'b0, req.addr};
    assign hit = wr_go && (off < (req.byte_op ? (ADDR_W+1)'(1) : (ADDR_W+1)'(BYTES)));
    assign wb  = 8'(req.wdata >> {off, 3'b000});

    always_ff @(posedge clk)
      if (hit) q <= wb;

    assign cell_q[g] = q;
  end
endmodule

// File: tb/tb_data_memory_ws.sv
// Directed bench: one instance with no wait states, one with two wait states.
module tb_data_memory_ws;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic        req_write [2];
  logic        req_byte [2];
  logic        req_signed [2];
  logic [15:0] address [2];
  logic [15:0] write_data [2];
  logic        ready [2];
  logic        resp_valid [2];
  logic        fault [2];
  logic [15:0] read_data [2];
  int checks = 0;
  int failures = 0;

  data_memory_ws #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .ready(ready[0]),
    .req_write(req_write[0]), .req_byte(req_byte[0]), .req_signed(req_signed[0]),
    .address(address[0]), .write_data(write_data[0]), .resp_valid(resp_valid[0]),
    .read_data(read_data[0]), .fault(fault[0]));

  data_memory_ws #(.WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .ready(ready[1]),
    .req_write(req_write[1]), .req_byte(req_byte[1]), .req_signed(req_signed[1]),
    .address(address[1]), .write_data(write_data[1]), .resp_valid(resp_valid[1]),
    .read_data(read_data[1]), .fault(fault[1]));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One request, then check latency, busy length, response, pulse width and hold.
  task automatic acc(input int d, input int wc, input logic w, input logic b, input logic s,
                     input logic [15:0] a, input logic [15:0] wd,
                     input logic [15:0] exp_rd, input logic exp_flt, input string tag);
    int n;
    int busy;
    logic got;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_write[d] = w; req_byte[d] = b; req_signed[d] = s;
    address[d] = a; write_data[d] = wd;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    n = 0; busy = 0; got = 1'b0;
    while (!got && n < 20) begin
      if (!ready[d]) busy++;
      @(posedge clk); #1;
      n++;
      got = resp_valid[d];
    end
    chk({tag, ".latency"}, 32'(n), 32'(wc + 1));
    chk({tag, ".busy"}, 32'(busy), 32'(wc + 1));
    chk({tag, ".data"}, 32'(read_data[d]), 32'(exp_rd));
    chk({tag, ".fault"}, 32'(fault[d]), 32'(exp_flt));
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 32'(resp_valid[d]), 32'd0);
    chk({tag, ".hold"}, 32'(read_data[d]), 32'(exp_rd));
  endtask

  // req_valid held high over four sequential word loads at 0,2,4,6.
  task automatic b2b(input int d, input int wc, input string tag);
    int sent = 0;
    int got = 0;
    int last = -1;
    int cyc = 0;
    int extra = 0;
    req_write[d] = 1'b0; req_byte[d] = 1'b0; req_signed[d] = 1'b0;
    while (got < 4 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (resp_valid[d]) begin
        chk({tag, ".data"}, 32'(read_data[d]), 32'(2 * got));
        if (last >= 0) chk({tag, ".gap"}, 32'(cyc - last), 32'(wc + 2));
        last = cyc;
        got++;
      end
      if (ready[d] && sent < 4) begin
        req_valid[d] = 1'b1;
        address[d] = 16'(2 * sent);
        sent++;
      end else if (ready[d]) begin
        req_valid[d] = 1'b0;
      end
    end
    req_valid[d] = 1'b0;
    chk({tag, ".count"}, 32'(got), 32'd4);
    repeat (6) begin
      @(negedge clk);
      if (resp_valid[d]) extra++;
    end
    chk({tag, ".extra"}, 32'(extra), 32'd0);
  endtask

  initial begin
    int spurious;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_byte[d] = 1'b0; req_signed[d] = 1'b0;
      address[d] = '0; write_data[d] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst.ready", 32'(ready[d]), 32'd1);
      chk("rst.resp_valid", 32'(resp_valid[d]), 32'd0);
      chk("rst.fault", 32'(fault[d]), 32'd0);
      chk("rst.read_data", 32'(read_data[d]), 32'd0);
    end

    acc(0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0, 16'h0000, 1'b0, "init_ld0");
    acc(0, 0, 1'b0, 1'b0, 1'b0, 16'h0002, 16'h0, 16'h0002, 1'b0, "init_ld2");
    acc(0, 0, 1'b0, 1'b0, 1'b0, 16'h0030, 16'h0, 16'h0030, 1'b0, "init_ld48");
    acc(0, 0, 1'b0, 1'b0, 1'b0, 16'h0032, 16'h0, 16'h0000, 1'b0, "init_ld50");

    b2b(0, 0, "b2b_w0");
    b2b(1, 2, "b2b_w2");

    acc(1, 2, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, "st_beef");
    acc(1, 2, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b0, "ld_beef");
    acc(1, 2, 1'b0, 1'b1, 1'b1, 16'h0011, 16'h0, 16'hFFBE, 1'b0, "ldb_signed");
    acc(1, 2, 1'b0, 1'b1, 1'b0, 16'h0011, 16'h0, 16'h00BE, 1'b0, "ldb_unsigned");
    acc(1, 2, 1'b1, 1'b1, 1'b0, 16'h0021, 16'h005A, 16'h0000, 1'b0, "stb_5a");
    acc(1, 2, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0, 16'h5A20, 1'b0, "ld_merge");
    acc(1, 2, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0, 16'h0000, 1'b1, "ld_misaligned");
    acc(1, 2, 1'b1, 1'b0, 1'b0, 16'h03FF, 16'hFFFF, 16'h0000, 1'b1, "st_top_word");
    acc(1, 2, 1'b0, 1'b1, 1'b0, 16'h03FF, 16'h0, 16'h0000, 1'b0, "ldb_top_unchanged");
    acc(1, 2, 1'b1, 1'b1, 1'b0, 16'h03FF, 16'h0077, 16'h0000, 1'b0, "stb_top");
    acc(1, 2, 1'b0, 1'b1, 1'b0, 16'h03FF, 16'h0, 16'h0077, 1'b0, "ldb_top");
    acc(1, 2, 1'b0, 1'b0, 1'b0, 16'h03FE, 16'h0, 16'h7700, 1'b0, "ld_top_word");
    acc(1, 2, 1'b0, 1'b1, 1'b0, 16'h0400, 16'h0, 16'h0000, 1'b1, "ldb_oor");
    acc(1, 2, 1'b1, 1'b0, 1'b0, 16'h0400, 16'h1111, 16'h0000, 1'b1, "st_oor");

    // Reset while the store of 0x1234 to 0x0030 is still in its wait states.
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_byte[1] = 1'b0; req_signed[1] = 1'b0;
    address[1] = 16'h0030; write_data[1] = 16'h1234;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("midrst.busy", 32'(ready[1]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst.ready_async", 32'(ready[1]), 32'd1);
    chk("midrst.no_resp", 32'(resp_valid[1]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst.ready_release", 32'(ready[1]), 32'd1);
    spurious = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid[1]) spurious++;
    end
    chk("midrst.spurious", 32'(spurious), 32'd0);
    acc(1, 2, 1'b0, 1'b0, 1'b0, 16'h0030, 16'h0, 16'h0030, 1'b0, "midrst.ld");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
